// File: rtl/bcd_7seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver for a packed BCD value.
// The displayed value is frozen once per scan frame, so a frame never shows two different counts.
module bcd_7seg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk50,
    input  logic        sys_init_n,
    input  logic [15:0] bcdint,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic             POL       = ACTIVE_LOW;
    localparam logic [6:0]       SEG_OFF   = {7{POL}};
    localparam logic [3:0]       AN_OFF    = {4{POL}};

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_e;

    dig_e              dig_q, dig_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [15:0]       snap_q, snap_d;
    logic [3:0]        snap_dp_q, snap_dp_d;
    logic              load_pend_q, load_pend_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic              frame_done_q, frame_done_d;

    logic              tc_s;
    logic              frame_end_s;
    logic [3:0]        lz_blank_s;
    logic [3:0]        cur_nib_s;
    logic              cur_dp_s;
    logic              cur_blank_s;
    logic              lit_s;

    // Logical (active-high) glyph for one BCD nibble; anything above 9 shows a dash.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // Dwell counter: tc marks the last cycle of a digit dwell.
    always_comb begin
        tc_s        = (div_cnt_q == CNT_LAST);
        frame_end_s = tc_s && (dig_q == DIG3);
        if (tc_s) begin
            div_cnt_d = {CNT_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end
    end

    // Digit rotation next-state; moves only at the end of a dwell.
    always_comb begin
        dig_d = dig_q;
        if (tc_s) begin
            case (dig_q)
                DIG0:    dig_d = DIG1;
                DIG1:    dig_d = DIG2;
                DIG2:    dig_d = DIG3;
                DIG3:    dig_d = DIG0;
                default: dig_d = DIG0;
            endcase
        end else begin
            dig_d = dig_q;
        end
    end

    // Snapshot capture: once right after reset, then only at the frame boundary.
    always_comb begin
        snap_d       = snap_q;
        snap_dp_d    = snap_dp_q;
        load_pend_d  = load_pend_q;
        frame_done_d = frame_end_s;
        if (load_pend_q || frame_end_s) begin
            snap_d      = bcdint;
            snap_dp_d   = dp_mask;
            load_pend_d = 1'b0;
        end else begin
            snap_d      = snap_q;
            snap_dp_d   = snap_dp_q;
            load_pend_d = load_pend_q;
        end
    end

    // Leading-zero mask; an invalid nibble is non-zero so it stops the blanking.
    always_comb begin
        lz_blank_s    = 4'b0000;
        lz_blank_s[0] = 1'b0;
        lz_blank_s[1] = BLANK_LZ && (snap_q[15:4]  == 12'h000);
        lz_blank_s[2] = BLANK_LZ && (snap_q[15:8]  == 8'h00);
        lz_blank_s[3] = BLANK_LZ && (snap_q[15:12] == 4'h0);
    end

    // Select the current digit's nibble, dp request and blank flag.
    always_comb begin
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b1;
        case (dig_q)
            DIG0: begin
                cur_nib_s   = snap_q[3:0];
                cur_dp_s    = snap_dp_q[0];
                cur_blank_s = lz_blank_s[0];
            end
            DIG1: begin
                cur_nib_s   = snap_q[7:4];
                cur_dp_s    = snap_dp_q[1];
                cur_blank_s = lz_blank_s[1];
            end
            DIG2: begin
                cur_nib_s   = snap_q[11:8];
                cur_dp_s    = snap_dp_q[2];
                cur_blank_s = lz_blank_s[2];
            end
            DIG3: begin
                cur_nib_s   = snap_q[15:12];
                cur_dp_s    = snap_dp_q[3];
                cur_blank_s = lz_blank_s[3];
            end
            default: begin
                cur_nib_s   = 4'h0;
                cur_dp_s    = 1'b0;
                cur_blank_s = 1'b1;
            end
        endcase
    end

    // Pin values for next cycle; segments are dark whenever no anode is driven.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = POL;
        an_d  = AN_OFF;
        lit_s = (div_cnt_q >= BLANK_END) && !cur_blank_s;
        if (lit_s) begin
            an_d  = AN_OFF ^ (4'b0001 << dig_q);
            seg_d = seg7_decode(cur_nib_s) ^ SEG_OFF;
            dp_d  = cur_dp_s ? ~POL : POL;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = POL;
        end
    end

    // Digit-rotation state register.
    always_ff @(posedge clk50 or negedge sys_init_n) begin
        if (!sys_init_n) begin
            dig_q <= DIG0;
        end else begin
            dig_q <= dig_d;
        end
    end

    // Datapath and registered pin drivers.
    always_ff @(posedge clk50 or negedge sys_init_n) begin
        if (!sys_init_n) begin
            div_cnt_q    <= {CNT_W{1'b0}};
            snap_q       <= 16'h0000;
            snap_dp_q    <= 4'b0000;
            load_pend_q  <= 1'b1;
            seg_q        <= SEG_OFF;
            dp_q         <= POL;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            load_pend_q  <= load_pend_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Randomized bench for bcd_7seg_scan_driver; expected pins come from a cycle-count based
// model of the scan (digit = cycle/dwell mod 4, frame = cycle/(4*dwell)) and the glyph table.
module tb_bcd_7seg_scan_driver;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    localparam logic [6:0] GLYPH [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk50 = 1'b0;
    logic        sys_init_n;
    logic [15:0] bcdint;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int          checks   = 0;
    int          failures = 0;
    int          edge_n;
    logic [15:0] snap_m;
    logic [3:0]  sdp_m;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_fd;

    bcd_7seg_scan_driver #(
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC),
        .ACTIVE_LOW (1'b1),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk50     (clk50),
        .sys_init_n(sys_init_n),
        .bcdint    (bcdint),
        .dp_mask   (dp_mask),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk50 = ~clk50;

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cycle=%0d t=%0t", tag, got, exp, edge_n, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        if (d > 4'd9) return 7'h40;
        return GLYPH[d];
    endfunction

    function automatic bit lead_blank(input logic [15:0] v, input int k);
        if (k == 0) return 1'b0;
        for (int j = k; j < 4; j++) begin
            if (v[4*j +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int j = 0; j < 4; j++) begin
            if ($urandom_range(0, 2) == 0) v[4*j +: 4] = 4'h0;
            else                           v[4*j +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    // Expected pins after edge n, using the value frozen for the frame edge n belongs to.
    task automatic compute_exp(input int n);
        int k;
        int ph;
        k       = (n / RD) % 4;
        ph      = n % RD;
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_fd  = ((n % FRAME) == FRAME - 1);
        if (ph >= BC && !lead_blank(snap_m, k)) begin
            exp_an[k] = 1'b0;
            exp_seg   = ~glyph(snap_m[4*k +: 4]);
            exp_dp    = ~sdp_m[k];
        end
    endtask

    task automatic do_cycle();
        @(posedge clk50);
        compute_exp(edge_n);
        if (edge_n == 0 || (edge_n % FRAME) == FRAME - 1) begin
            snap_m = bcdint;
            sdp_m  = dp_mask;
        end
        @(negedge clk50);
        chk_val("an",         16'(an),                exp_an);
        chk_val("seg",        16'(seg),               exp_seg);
        chk_val("dp",         16'(dp),                exp_dp);
        chk_val("frame_done", 16'(frame_done),        exp_fd);
        chk_val("an_onehot0", 16'($onehot0(~an)),     16'd1);
        edge_n++;
    endtask

    task automatic check_idle(input string tag);
        chk_val({tag, "_an"},  16'(an),         16'h000F);
        chk_val({tag, "_seg"}, 16'(seg),        16'h007F);
        chk_val({tag, "_dp"},  16'(dp),         16'h0001);
        chk_val({tag, "_fd"},  16'(frame_done), 16'h0000);
    endtask

    task automatic release_reset();
        sys_init_n = 1'b1;
        edge_n     = 0;
        snap_m     = 16'h0000;
        sdp_m      = 4'b0000;
    endtask

    initial begin
        sys_init_n = 1'b0;
        bcdint     = 16'h0205;
        dp_mask    = 4'b0000;
        edge_n     = 0;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        check_idle("reset");
        release_reset();

        // Held 0205, then a change to 0359 in the middle of the second frame's digit-1 dwell.
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (edge_n == FRAME + RD + 2) bcdint = 16'h0359;
            do_cycle();
        end

        bcdint = 16'h0000;
        for (int i = 0; i < 2 * FRAME; i++) do_cycle();

        bcdint  = 16'h9A09;
        dp_mask = 4'b0100;
        for (int i = 0; i < 2 * FRAME; i++) do_cycle();

        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bcdint  = rand_bcd();
                dp_mask = 4'($urandom_range(0, 15));
            end
            do_cycle();
        end

        // Asynchronous reset in the middle of the digit-2 dwell.
        bcdint  = 16'h0802;
        dp_mask = 4'b1111;
        for (int i = 0; i < FRAME && (edge_n % FRAME) != 2 * RD + 4; i++) do_cycle();
        sys_init_n = 1'b0;
        #1;
        check_idle("midrst");
        @(posedge clk50);
        @(negedge clk50);
        check_idle("midrst_hold");
        bcdint  = 16'h1234;
        dp_mask = 4'b0001;
        release_reset();
        for (int i = 0; i < 3 * FRAME; i++) do_cycle();

        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bcdint  = rand_bcd();
                dp_mask = 4'($urandom_range(0, 15));
            end
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
